systolic_tensor_array_pipelined: RTL and testbench
==================================================

SYSTOLIC_TENSOR_ARRAY_PIPELINED -- requirements
Module: systolic_tensor_array_pipelined

Interface
REQ-001 Parameter N, default 4: array dimension; the block has NxN processing elements.
REQ-002 Parameter TILE_SIZE, default 2: tile edge; elaboration SHALL fail unless N % TILE_SIZE == 0 and TILE_SIZE >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 A_in  input  [N][N] x int8 signed  operand matrix A; A_in[i][k] is row i, column k.
REQ-006 B_in  input  [N][N] x int8 signed  operand matrix B; B_in[k][j] is row k, column j.
REQ-007 load_sum  input  [N][N] x 1  per-PE accumulate select.
REQ-008 C_out  output  [N][N] x int32 signed  registered result; C_out[i][j] is driven by PE (i,j).

Function
REQ-009 The block SHALL instantiate N*N tensor_process_element instances, one per (r,c).
- Each PE receives row r of A (N elements) and column c of B (N elements).
- Each PE receives load_sum[r][c].
REQ-010 Each PE SHALL form dot = sum over k of A[r][k]*B[k][c].
- Products: signed int8 x int8 giving 16-bit results.
- Products are sign-extended to 32 bits before summation.
REQ-011 Each PE SHALL update its accumulator every cycle:
- load_sum=0: acc <= dot (overwrite).
- load_sum=1: acc <= acc + dot.
REQ-012 Accumulator arithmetic SHALL be 32-bit two's complement and wrap on overflow; there is no saturation.
REQ-013 C_out[r][c] SHALL equal the PE accumulator register; there is no combinational path from any input to C_out.
REQ-014 Inter-tile pipelining:
- A operands crossing each row-tile boundary pass through one register.
- B operands crossing each column-tile boundary pass through one register.
- load_sum is delayed identically.
- Operands and load_sum reaching PE (r,c) are therefore delayed D(r,c) = floor(r/TILE_SIZE) + floor(c/TILE_SIZE) cycles.
- All operands at a PE SHALL originate from the same input cycle.
- No registers exist within a tile.
REQ-015 Latency: inputs sampled at edge t SHALL appear on C_out[r][c] after edge t + D(r,c) + 1 cycles' worth of register stages (i.e. visible following edge t+D(r,c)).
REQ-016 With constant inputs and load_sum all 0, C_out SHALL settle to A x B within max D + 1 cycles and remain stable.
REQ-017 When reset and load_sum=1 coincide, reset SHALL take priority.

Reset
REQ-018 While reset=1 at a clock edge, the following SHALL clear to 0:
- every PE accumulator;
- every inter-tile operand register;
- every load_sum pipeline register.
REQ-019 C_out SHALL read 0 from the first edge after reset is asserted until a post-reset result arrives.
REQ-020 Reset asserted mid-accumulation SHALL discard all partial sums and in-flight operands.
REQ-021 The first result after reset deassertion SHALL be a fresh dot product, with no residue from before reset.

Configuration
REQ-022 Macro STA_TILE_PIPE_EN:
- Defined: the inter-tile registers of REQ-014 are present.
- Undefined: D(r,c) = 0 for all PEs, every C_out has 1-cycle latency, and no inter-tile registers are synthesized.
- Arithmetic behaviour SHALL be identical in both builds.

Verification
REQ-023 N=2, TILE_SIZE=2, reset for 1 cycle.
- Stimulus: A=[[1,2],[3,4]], B=[[5,6],[7,8]] held, load_sum=0.
- Response: C_out=[[19,22],[43,50]] from the first edge after reset, still stable 5 cycles later.
REQ-024 Accumulate: same operands with load_sum all 1 after a 0 cycle -> C_out[0][0] = 19, 38, 57, and C_out[1][1] = 50, 100, 150 on consecutive edges.
REQ-025 Extremes, N=4:
- A all -128, B all -128 -> every C_out = 65536.
- A all -128, B all 127 -> every C_out = -65024.
- Accumulating 0x7FFFFFFF + 1 wraps to -2147483648.
REQ-026 Latency, N=4, TILE_SIZE=2, macro defined.
- Stimulus: step from zero operands to A=identity, B=all 2.
- Response: C_out[0][0]=2 after 1 cycle; C_out[0][3] and C_out[3][0] after 2 cycles; C_out[3][3] after 3 cycles.
- With the macro undefined, all entries update after 1 cycle.
REQ-027 Reset mid-operation: assert reset while accumulating -> all C_out = 0 at the next edge; after release, the first result equals the single dot product only.

Source files
------------

// File: rtl/systolic_tensor_array_pipelined.sv
// -----------------------------------------------------------------------------
// systolic_tensor_array_pipelined
//
// NxN array of multiply-accumulate processing elements. PE (r,c) forms the
// int8 dot product of row r of A with column c of B every cycle and either
// overwrites or adds it into its 32-bit wrapping accumulator (load_sum
// selects). The PEs are grouped into TILE_SIZE x TILE_SIZE tiles. When the
// optional inter-tile pipelining is enabled, the operands and the load_sum
// bits reaching a tile are delayed by one register per tile boundary crossed.
// That is (tile row + tile column) cycles. PEs inside a tile see the same
// delay, so every operand at a PE comes from the same input cycle.
//
// Configuration macro: STA_TILE_PIPE_EN
//   defined   - inter-tile registers present, delay D(r,c) = r/TS + c/TS
//   undefined - no inter-tile registers, every C_out has 1-cycle latency
//
// Ports (all flattened, row-major, element 0 in the LSBs):
//   clk       in   1          rising-edge clock
//   reset     in   1          synchronous active-high reset
//   A_in      in   N*N*8      A[i][k] at bits [(i*N+k)*8 +: 8], signed
//   B_in      in   N*N*8      B[k][j] at bits [(k*N+j)*8 +: 8], signed
//   load_sum  in   N*N        PE (r,c) accumulate select at bit r*N+c
//   C_out     out  N*N*32     PE (r,c) accumulator at bits [(r*N+c)*32 +: 32]
// -----------------------------------------------------------------------------

module tensor_process_element #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*8-1:0] a_row_i,
    input  logic [N*8-1:0] b_col_i,
    input  logic           load_sum_i,
    output logic [31:0]    acc_o
);

    // Signed int8 x int8 -> 16-bit products, sign-extended and summed in 32 bits.
    function automatic logic signed [31:0] dot_product(input logic [N*8-1:0] a,
                                                       input logic [N*8-1:0] b);
        logic signed [31:0] sum;
        logic signed [7:0]  a_k;
        logic signed [7:0]  b_k;
        logic signed [15:0] prod;
        sum = '0;
        for (int k = 0; k < N; k++) begin
            a_k  = a[k*8 +: 8];
            b_k  = b[k*8 +: 8];
            prod = 16'(a_k) * 16'(b_k);
            sum  = sum + 32'(prod);
        end
        return sum;
    endfunction

    logic signed [31:0] dot_p0;
    logic signed [31:0] acc_d;
    logic signed [31:0] acc_q;

    always_comb begin
        dot_p0 = dot_product(a_row_i, b_col_i);
        acc_d  = load_sum_i ? (acc_q + dot_p0) : dot_p0;
    end

    // Stage boundary: accumulator register, which is also the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

module systolic_tensor_array_pipelined #(
    parameter int N         = 4,
    parameter int TILE_SIZE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*N*8-1:0]  A_in,
    input  logic [N*N*8-1:0]  B_in,
    input  logic [N*N-1:0]    load_sum,
    output logic [N*N*32-1:0] C_out
);

    // Guarded copy of TILE_SIZE so loop bounds stay legal while the
    // elaboration check below reports the bad configuration.
    localparam int TS = (TILE_SIZE < 1) ? 1 : TILE_SIZE;
    localparam int NT = N / TS;
    localparam int AW = TS * N * 8;   // A rows belonging to one tile row
    localparam int BW = N * TS * 8;   // B columns belonging to one tile column
    localparam int LW = TS * TS;      // load_sum bits of one tile

    if (TILE_SIZE < 1) begin : g_bad_tile_size
        $error("TILE_SIZE must be at least 1");
    end else if ((N % TILE_SIZE) != 0) begin : g_bad_tile_split
        $error("N must be a multiple of TILE_SIZE");
    end

    for (genvar tr = 0; tr < NT; tr++) begin : g_tile_row
        for (genvar tc = 0; tc < NT; tc++) begin : g_tile_col
            logic [AW-1:0] a_p0;
            logic [BW-1:0] b_p0;
            logic [LW-1:0] ls_p0;
            logic [AW-1:0] a_tile;
            logic [BW-1:0] b_tile;
            logic [LW-1:0] ls_tile;

            // Gather this tile's operands straight from the ports.
            assign a_p0 = A_in[tr*AW +: AW];
            for (genvar k = 0; k < N; k++) begin : g_b_gather
                for (genvar jj = 0; jj < TS; jj++) begin : g_b_col
                    assign b_p0[(k*TS+jj)*8 +: 8] = B_in[(k*N + tc*TS + jj)*8 +: 8];
                end
            end
            for (genvar ii = 0; ii < TS; ii++) begin : g_ls_row
                for (genvar jj = 0; jj < TS; jj++) begin : g_ls_col
                    assign ls_p0[ii*TS+jj] = load_sum[(tr*TS + ii)*N + tc*TS + jj];
                end
            end

`ifdef STA_TILE_PIPE_EN
            // One register per tile boundary crossed on the way to this tile.
            localparam int TD = tr + tc;
            if (TD == 0) begin : g_direct
                assign a_tile  = a_p0;
                assign b_tile  = b_p0;
                assign ls_tile = ls_p0;
            end else begin : g_pipe
                logic [AW-1:0] a_q  [TD];
                logic [BW-1:0] b_q  [TD];
                logic [LW-1:0] ls_q [TD];

                // Stage boundaries: inter-tile delay chain, cleared by reset so
                // no in-flight operand survives it.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        for (int d = 0; d < TD; d++) begin
                            a_q[d]  <= '0;
                            b_q[d]  <= '0;
                            ls_q[d] <= '0;
                        end
                    end else begin
                        a_q[0]  <= a_p0;
                        b_q[0]  <= b_p0;
                        ls_q[0] <= ls_p0;
                        for (int d = 1; d < TD; d++) begin
                            a_q[d]  <= a_q[d-1];
                            b_q[d]  <= b_q[d-1];
                            ls_q[d] <= ls_q[d-1];
                        end
                    end
                end

                assign a_tile  = a_q[TD-1];
                assign b_tile  = b_q[TD-1];
                assign ls_tile = ls_q[TD-1];
            end
`else
            assign a_tile  = a_p0;
            assign b_tile  = b_p0;
            assign ls_tile = ls_p0;
`endif

            // PEs inside a tile share the tile's operands with no extra delay.
            for (genvar ii = 0; ii < TS; ii++) begin : g_pe_row
                for (genvar jj = 0; jj < TS; jj++) begin : g_pe_col
                    logic [N*8-1:0] b_col;
                    for (genvar k = 0; k < N; k++) begin : g_pe_b
                        assign b_col[k*8 +: 8] = b_tile[(k*TS+jj)*8 +: 8];
                    end

                    tensor_process_element #(
                        .N (N)
                    ) u_pe (
                        .clk        (clk),
                        .reset      (reset),
                        .a_row_i    (a_tile[ii*N*8 +: N*8]),
                        .b_col_i    (b_col),
                        .load_sum_i (ls_tile[ii*TS+jj]),
                        .acc_o      (C_out[((tr*TS+ii)*N + tc*TS + jj)*32 +: 32])
                    );
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_tensor_array_pipelined.sv
module tb_systolic_tensor_array_pipelined;

    logic clk;
    logic rst;

    logic [2*2*8-1:0]  a2;
    logic [2*2*8-1:0]  b2;
    logic [3:0]        ls2;
    logic [2*2*32-1:0] c2;

    logic [4*4*8-1:0]  a4;
    logic [4*4*8-1:0]  b4;
    logic [15:0]       ls4;
    logic [4*4*32-1:0] c4;

    int checks;
    int errors;

    systolic_tensor_array_pipelined #(.N(2), .TILE_SIZE(2)) dut2 (
        .clk      (clk),
        .reset    (rst),
        .A_in     (a2),
        .B_in     (b2),
        .load_sum (ls2),
        .C_out    (c2)
    );

    systolic_tensor_array_pipelined #(.N(4), .TILE_SIZE(2)) dut4 (
        .clk      (clk),
        .reset    (rst),
        .A_in     (a4),
        .B_in     (b4),
        .load_sum (ls4),
        .C_out    (c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              a_ident;  // 1: A = a_val * identity, 0: A all a_val
        logic signed [7:0] a_val;
        logic signed [7:0] b_val;    // B all b_val
        logic signed [31:0] exp;     // expected value of every C entry
    } vec_t;

    vec_t vecs [7];

    // Pipeline delay of PE (r,c) in the N=4, TILE_SIZE=2 array.
    function automatic int pe_delay(input int r, input int c);
`ifdef STA_TILE_PIPE_EN
        return r / 2 + c / 2;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [31:0] c2_at(input int r, input int c);
        return c2[(r*2+c)*32 +: 32];
    endfunction

    function automatic logic [31:0] c4_at(input int r, input int c);
        return c4[(r*4+c)*32 +: 32];
    endfunction

    task automatic set4(input logic ident, input logic signed [7:0] av, input logic signed [7:0] bv);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                a4[(i*4+k)*8 +: 8] = (ident && i != k) ? 8'sd0 : av;
                b4[(i*4+k)*8 +: 8] = bv;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{"neg_neg",   1'b0, -8'sd128, -8'sd128, 32'sd65536};
        vecs[1] = '{"neg_pos",   1'b0, -8'sd128,  8'sd127, -32'sd65024};
        vecs[2] = '{"pos_pos",   1'b0,  8'sd127,  8'sd127, 32'sd64516};
        vecs[3] = '{"ident_2",   1'b1,  8'sd1,    8'sd2,   32'sd2};
        vecs[4] = '{"ident_neg", 1'b1, -8'sd3,    8'sd7,   -32'sd21};
        vecs[5] = '{"zero_a",    1'b0,  8'sd0,   -8'sd128, 32'sd0};
        vecs[6] = '{"mixed",     1'b0,  8'sd5,   -8'sd6,   -32'sd120};

        // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
        rst = 1'b1;
        a2  = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
        b2  = {8'sd8, 8'sd7, 8'sd6, 8'sd5};
        ls2 = 4'b0000;
        a4  = '0;
        b4  = '0;
        ls4 = '0;

        step();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                chk($sformatf("reset2_c%0d%0d", r, c), c2_at(r, c), 32'd0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("reset4_c%0d%0d", r, c), c4_at(r, c), 32'd0);

        // Basic product, visible from the first edge after reset.
        rst = 1'b0;
        step();
        chk("mm_c00", c2_at(0, 0), 32'd19);
        chk("mm_c01", c2_at(0, 1), 32'd22);
        chk("mm_c10", c2_at(1, 0), 32'd43);
        chk("mm_c11", c2_at(1, 1), 32'd50);
        repeat (5) step();
        chk("hold_c00", c2_at(0, 0), 32'd19);
        chk("hold_c01", c2_at(0, 1), 32'd22);
        chk("hold_c10", c2_at(1, 0), 32'd43);
        chk("hold_c11", c2_at(1, 1), 32'd50);

        // Accumulate after a load_sum=0 cycle (the current value is 19/50).
        ls2 = 4'b1111;
        step();
        chk("acc1_c00", c2_at(0, 0), 32'd38);
        chk("acc1_c11", c2_at(1, 1), 32'd100);
        step();
        chk("acc2_c00", c2_at(0, 0), 32'd57);
        chk("acc2_c11", c2_at(1, 1), 32'd150);

        // Reset while accumulating wins over load_sum and discards partial sums.
        rst = 1'b1;
        step();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                chk($sformatf("midrst_c%0d%0d", r, c), c2_at(r, c), 32'd0);
        rst = 1'b0;
        step();
        chk("postrst_c00", c2_at(0, 0), 32'd19);
        chk("postrst_c01", c2_at(0, 1), 32'd22);
        chk("postrst_c10", c2_at(1, 0), 32'd43);
        chk("postrst_c11", c2_at(1, 1), 32'd50);

        // Latency step on the 4x4 array: zero operands -> A=I, B=all 2.
        set4(1'b0, 8'sd0, 8'sd0);
        repeat (3) step();
        set4(1'b1, 8'sd1, 8'sd2);
        for (int s = 1; s <= 3; s++) begin
            step();
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    chk($sformatf("lat_s%0d_c%0d%0d", s, r, c), c4_at(r, c),
                        (s >= pe_delay(r, c) + 1) ? 32'd2 : 32'd0);
        end

        // Table-driven uniform / identity vectors, overwrite mode.
        for (int v = 0; v < 7; v++) begin
            set4(vecs[v].a_ident, vecs[v].a_val, vecs[v].b_val);
            ls4 = '0;
            repeat (3) step();
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    chk($sformatf("%s_c%0d%0d", vecs[v].name, r, c), c4_at(r, c), vecs[v].exp);
        end

        // Wrap: PE(0,0) loads -1, then adds 65536 for 32768 cycles to reach
        // 0x7FFFFFFF, then adds 1.
        a4 = '0;
        b4 = '0;
        a4[7:0] = -8'sd1;
        b4[7:0] = 8'sd1;
        ls4 = '0;
        step();
        chk("wrap_seed", c4_at(0, 0), 32'hFFFF_FFFF);
        set4(1'b0, -8'sd128, -8'sd128);
        ls4 = '1;
        repeat (32767) @(posedge clk);
        step();
        chk("wrap_max", c4_at(0, 0), 32'h7FFF_FFFF);
        a4 = '0;
        b4 = '0;
        a4[7:0] = 8'sd1;
        b4[7:0] = 8'sd1;
        step();
        chk("wrap_min", c4_at(0, 0), 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
